// File: rtl/spi_cmd_pkg.sv
// Shared opcode, field-position and FSM definitions for the SPI command receiver.
package spi_cmd_pkg;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_DOT    = 2'b01;
  localparam logic [1:0] OP_SELCFG = 2'b10;
  localparam logic [1:0] OP_CTRL   = 2'b11;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 30;
  localparam int unsigned DRV_MSB   = 29;
  localparam int unsigned DRV_LSB   = 26;
  localparam int unsigned MASK_MSB  = 25;
  localparam int unsigned MASK_LSB  = 23;
  localparam int unsigned SEL_BIT   = 22;
  localparam int unsigned MADDR_MSB = 22;
  localparam int unsigned MADDR_LSB = 16;
  localparam int unsigned ROW_MSB   = 21;
  localparam int unsigned ROW_LSB   = 15;
  localparam int unsigned COL_MSB   = 14;
  localparam int unsigned COL_LSB   = 8;
  localparam int unsigned CFG_MSB   = 21;
  localparam int unsigned CFG_LSB   = 16;
  localparam int unsigned DATA_MSB  = 15;
  localparam int unsigned DATA_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    READY
  } state_t;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-stage pin synchronizer with a history flop for single-cycle edge pulses.
module input_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d);
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_command_receiver.sv
// SPI slave front end: assembles 32-bit MSB-first frames, decodes them into
// one-cycle command strobes on latch_data, and echoes the last command on miso.
module spi_command_receiver
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CMD_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss_n,
  input  logic        latch_data,
  output logic        miso,
  output logic        miso_oe,
  output logic        frame_error,
  output logic        mem_wr,
  output logic        dot_wr,
  output logic        sel_wr,
  output logic        cfg_wr,
  output logic        ctrl_wr,
  output logic [3:0]  driver_select,
  output logic [2:0]  update_mask,
  output logic [6:0]  mem_addr,
  output logic [15:0] data,
  output logic [6:0]  row_addr,
  output logic [6:0]  col_addr,
  output logic [5:0]  cfg_addr,
  output logic [3:0]  ctrl
);

  logic sclk_q_unused, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;
  logic ss_q, ss_rise, ss_fall;
  logic latch_q_unused, latch_rise, latch_fall_unused;

  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset_n(reset_n), .d(sclk),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d(mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  // ss_n resets deasserted so the FSM does not open a frame out of reset.
  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset_n(reset_n), .d(ss_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );
  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
    .clock(clock), .reset_n(reset_n), .d(latch_data),
    .q(latch_q_unused), .rise(latch_rise), .fall(latch_fall_unused)
  );

  assign miso_oe = ~ss_q;

  state_t               state_q, state_d;
  logic [CMD_WIDTH-1:0] shift_q, held_q, echo_q, cmd_q;
  logic [5:0]           count_q;
  logic                 dispatch_q;
  logic                 start, shift_en, miso_en, capture, err, dispatch;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    miso_en  = 1'b0;
    capture  = 1'b0;
    err      = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ss_q) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (count_q == 6'(CMD_WIDTH)) begin
            capture = 1'b1;
            state_d = READY;
          end else begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end else begin
          shift_en = sclk_rise;
          miso_en  = sclk_fall;
        end
      end
      READY: begin
        if (latch_rise) begin
          dispatch = 1'b1;
          state_d  = IDLE;
        end
        if (ss_fall) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame starting in the dispatch cycle echoes the frame being dispatched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      held_q      <= '0;
      echo_q      <= '0;
      cmd_q       <= '0;
      count_q     <= '0;
      miso        <= 1'b0;
      frame_error <= 1'b0;
      dispatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_error <= err;
      dispatch_q  <= dispatch;
      if (start) begin
        shift_q <= dispatch ? held_q : echo_q;
        miso    <= dispatch ? held_q[CMD_WIDTH-1] : echo_q[CMD_WIDTH-1];
        count_q <= '0;
      end
      if (shift_en) begin
        shift_q <= {shift_q[CMD_WIDTH-2:0], mosi_q};
        if (count_q != 6'(CMD_WIDTH + 1)) count_q <= count_q + 6'd1;
      end
      if (miso_en) miso <= shift_q[CMD_WIDTH-1];
      if (capture) held_q <= shift_q;
      if (dispatch) begin
        echo_q <= held_q;
        cmd_q  <= held_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr        <= 1'b0;
      dot_wr        <= 1'b0;
      sel_wr        <= 1'b0;
      cfg_wr        <= 1'b0;
      ctrl_wr       <= 1'b0;
      driver_select <= '0;
      update_mask   <= '0;
      mem_addr      <= '0;
      data          <= '0;
      row_addr      <= '0;
      col_addr      <= '0;
      cfg_addr      <= '0;
      ctrl          <= '0;
    end else begin
      mem_wr  <= 1'b0;
      dot_wr  <= 1'b0;
      sel_wr  <= 1'b0;
      cfg_wr  <= 1'b0;
      ctrl_wr <= 1'b0;
      if (dispatch_q) begin
        case (cmd_q[OPC_MSB:OPC_LSB])
          OP_MEM:    mem_wr  <= 1'b1;
          OP_DOT:    dot_wr  <= 1'b1;
          OP_SELCFG: begin
            sel_wr <= cmd_q[SEL_BIT];
            cfg_wr <= ~cmd_q[SEL_BIT];
          end
          default:   ctrl_wr <= 1'b1;
        endcase
        driver_select <= cmd_q[DRV_MSB:DRV_LSB];
        update_mask   <= cmd_q[MASK_MSB:MASK_LSB];
        mem_addr      <= cmd_q[MADDR_MSB:MADDR_LSB];
        data          <= cmd_q[DATA_MSB:DATA_LSB];
        row_addr      <= cmd_q[ROW_MSB:ROW_LSB];
        col_addr      <= cmd_q[COL_MSB:COL_LSB];
        cfg_addr      <= cmd_q[CFG_MSB:CFG_LSB];
        ctrl          <= cmd_q[DRV_MSB:DRV_LSB];
      end
    end
  end

endmodule

// File: tb/tb_spi_command_receiver.sv
// Directed bench for spi_command_receiver: bit-banged SPI frames, latch dispatch,
// echo readback, malformed frames and reset mid-frame.
module tb_spi_command_receiver;

  logic        clock;
  logic        reset_n;
  logic        sclk, mosi, ss_n, latch_data;
  logic        miso, miso_oe, frame_error;
  logic        mem_wr, dot_wr, sel_wr, cfg_wr, ctrl_wr;
  logic [3:0]  driver_select;
  logic [2:0]  update_mask;
  logic [6:0]  mem_addr;
  logic [15:0] data;
  logic [6:0]  row_addr;
  logic [6:0]  col_addr;
  logic [5:0]  cfg_addr;
  logic [3:0]  ctrl;

  spi_command_receiver #(.CMD_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .latch_data(latch_data), .miso(miso), .miso_oe(miso_oe),
    .frame_error(frame_error), .mem_wr(mem_wr), .dot_wr(dot_wr),
    .sel_wr(sel_wr), .cfg_wr(cfg_wr), .ctrl_wr(ctrl_wr),
    .driver_select(driver_select), .update_mask(update_mask),
    .mem_addr(mem_addr), .data(data), .row_addr(row_addr),
    .col_addr(col_addr), .cfg_addr(cfg_addr), .ctrl(ctrl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_mem = 0, n_dot = 0, n_sel = 0, n_cfg = 0, n_ctrl = 0, n_err = 0;
  logic [31:0] rx;
  logic        oe_mid;

  // Strobe-high cycles are counted on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (mem_wr)      n_mem++;
    if (dot_wr)      n_dot++;
    if (sel_wr)      n_sel++;
    if (cfg_wr)      n_cfg++;
    if (ctrl_wr)     n_ctrl++;
    if (frame_error) n_err++;
  end

  function automatic logic [19:0] strobe_word();
    return {4'(n_mem), 4'(n_dot), 4'(n_sel), 4'(n_cfg), 4'(n_ctrl)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    wait_clk(5);
    sclk = 1'b1;
    rx = {rx[30:0], miso};
    wait_clk(5);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits);
    logic [63:0] v;
    v  = {word, 32'h0};
    rx = '0;
    ss_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      send_bit(v[63-i]);
      if (i == 10) oe_mid = miso_oe;
    end
    wait_clk(5);
    ss_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic latch_cmd(output int lat);
    lat = -1;
    latch_data = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wait_clk(1);
      if (lat < 0 && (mem_wr | dot_wr | sel_wr | cfg_wr | ctrl_wr)) lat = k;
    end
    latch_data = 1'b0;
    wait_clk(6);
  endtask

  function automatic logic [63:0] out_vec();
    return {2'b0, miso, miso_oe, frame_error, mem_wr, dot_wr, sel_wr, cfg_wr, ctrl_wr,
            driver_select, update_mask, mem_addr, data, row_addr, col_addr, cfg_addr, ctrl};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] base;
    int          e0;
    int          lat;

    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; latch_data = 1'b0;
    wait_clk(3);
    check("reset_outputs", out_vec(), 64'h0);
    reset_n = 1'b1;
    wait_clk(4);

    // mem write
    base = strobe_word(); e0 = n_err;
    check("oe_idle", miso_oe, 1'b0);
    send_frame(32'h0D051234, 32);
    check("echo_initial", rx, 32'h0);
    latch_cmd(lat);
    check("mem_strobe", strobe_word() - base, 20'h10000);
    check("mem_fields", {driver_select, update_mask, mem_addr, data},
          {4'd3, 3'd2, 7'd5, 16'h1234});
    check("mem_no_err", n_err - e0, 0);

    // cfg write, echo of previous command
    base = strobe_word();
    send_frame(32'h80060004, 32);
    check("echo_mem", rx, 32'h0D051234);
    check("oe_frame", oe_mid, 1'b1);
    latch_cmd(lat);
    check("cfg_strobe", strobe_word() - base, 20'h00010);
    check("cfg_fields", {cfg_addr, data}, {6'd6, 16'h0004});

    // sel write
    base = strobe_word();
    send_frame(32'h88418303, 32);
    check("echo_cfg", rx, 32'h80060004);
    latch_cmd(lat);
    check("sel_strobe", strobe_word() - base, 20'h00100);
    check("sel_fields", {driver_select, row_addr, col_addr, data[7:0], mem_addr},
          {4'd2, 7'd3, 7'd3, 8'h03, 7'h41});

    // ctrl write with latency
    base = strobe_word();
    send_frame(32'hE0000000, 32);
    latch_cmd(lat);
    check("ctrl_strobe", strobe_word() - base, 20'h00001);
    check("ctrl_value", ctrl, 4'b1000);
    check("latch_latency", lat, 4);

    // short frame
    base = strobe_word(); e0 = n_err;
    send_frame(32'h12345678, 31);
    check("err_31", n_err - e0, 1);
    latch_cmd(lat);
    check("no_strobe_31", strobe_word() - base, 20'h0);

    // long frame
    base = strobe_word(); e0 = n_err;
    send_frame(32'h12345678, 33);
    check("err_33", n_err - e0, 1);
    latch_cmd(lat);
    check("no_strobe_33", strobe_word() - base, 20'h0);
    check("fields_hold", {ctrl, data}, {4'b1000, 16'h0000});

    // reset mid-frame
    base = strobe_word(); e0 = n_err;
    ss_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    reset_n = 1'b0;
    wait_clk(2);
    check("reset_mid_outputs", out_vec(), 64'h0);
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(5);
    send_frame(32'h40000007, 32);
    check("echo_after_reset", rx, 32'h0);
    check("no_err_reset", n_err - e0, 0);
    latch_cmd(lat);
    check("dot_strobe", strobe_word() - base, 20'h01000);
    check("dot_data", data, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_command_receiver.md
Name: spi_command_receiver

Overview:
SPI-slave front end of the motor sequencer ASIC, the chip-side counterpart of the host command link.
- Oversamples sclk/mosi/ss_n/latch_data in the system clock domain and assembles 32-bit MSB-first frames.
- On a latch_data rising edge, decodes the held frame into one-cycle write strobes with field buses for the driver memories, dot data, row/col selects, backend config and control.
- Echoes the last dispatched command on miso during the next frame.

Parameters:
- CMD_WIDTH, 32, frame length in bits (fixed protocol width).
- SYNC_STAGES, 2, synchronizer depth for all pin inputs.

Ports:
- clock  input  1  system clock; sclk period must be ≥ 8 clock periods.
- reset_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock, idle low, gated by ss_n.
- mosi  input  1  SPI data in; changes on sclk falling, sampled on sclk rising.
- ss_n  input  1  active-low frame select.
- latch_data  input  1  rising edge commits the held frame.
- miso  output  1  SPI data out, updated on sclk falling.
- miso_oe  output  1  miso drive enable = synced ~ss_n.
- frame_error  output  1  one-cycle pulse when ss_n rises with bit count ≠ 32.
- mem_wr, dot_wr, sel_wr, cfg_wr, ctrl_wr  output  1 each  one-cycle command strobes.
- driver_select  output  4  cmd[29:26].
- update_mask  output  3  cmd[25:23].
- mem_addr  output  7  cmd[22:16].
- data  output  16  cmd[15:0].
- row_addr  output  7  cmd[21:15].
- col_addr  output  7  cmd[14:8].
- cfg_addr  output  6  cmd[21:16].
- ctrl  output  4  cmd[29:26] for opcode 11.

Behaviour:
- Reset: all outputs 0; shift register, echo register and bit count cleared; FSM in IDLE.
- Input path: all four pins pass through SYNC_STAGES flops, plus one history flop for edge detect.
- FSM IDLE: synced ss_n low → load shift_reg from echo register, clear count, go to SHIFT.
- FSM SHIFT, sclk rising: shift_reg ← {shift_reg[30:0], mosi}; count increments, saturating at 33.
- FSM SHIFT, sclk falling: miso ← shift_reg[31]. miso shows echo bit 31 as soon as the frame starts.
- FSM SHIFT, ss_n rising: count == 32 → capture shift_reg into held frame, go to READY. Otherwise pulse frame_error and go to IDLE.
- FSM READY: latch rising edge → dispatch, go to IDLE. ss_n falling with no latch → drop the held frame, go to SHIFT. Both in the same cycle → dispatch first, then enter SHIFT.
- Latch rising edge in IDLE or SHIFT: ignored, no strobe.
- Dispatch latency: latch_data sampled high at clock edge N → strobe and all field buses valid in the cycle after edge N+3. Strobe lasts exactly 1 cycle. Field buses hold their value until the next dispatch.
- Decode on cmd[31:30]:
  - 00 → mem_wr.
  - 01 → dot_wr.
  - 10 with cmd[22]=1 → sel_wr.
  - 10 with cmd[22]=0 → cfg_wr.
  - 11 → ctrl_wr.
- All field buses are driven from the held frame regardless of opcode. Exactly one strobe per dispatch.
- Echo register ← held frame on dispatch only.
- Async reset mid-frame or in READY: frame discarded, no strobe, no frame_error.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode constants OP_MEM=2'b00, OP_DOT=2'b01, OP_SELCFG=2'b10, OP_CTRL=2'b11;
  - field MSB/LSB localparams;
  - FSM state enum {IDLE, SHIFT, READY}.
- Sub-module input_synchronizer: parameterised-depth sync with rise/fall pulse outputs, instanced 4×.

Test Plan:
- Frame 0x0D051234 + latch → mem_wr once; driver_select=3, update_mask=2, mem_addr=5, data=0x1234; no other strobe.
- Frame 0x80060004 → cfg_wr; cfg_addr=6, data=0x0004. Frame 0x88418303 → sel_wr; driver_select=2, row_addr=3, col_addr=3, data[7:0]=0x03.
- Frame 0xE0000000 → ctrl_wr with ctrl=4'b1000. Measure latch-to-strobe delay = 4 clocks.
- 31-bit frame and 33-bit frame → frame_error pulse each; a following latch produces no strobe.
- After dispatching 0x0D051234, next frame's 32 miso bits sampled on sclk rising read 0x0D051234; miso_oe low while ss_n high.
- reset_n low at bit 16, then a full frame 0x40000007 + latch → dot_wr with data=7; no residue from the aborted frame.
